// File: rtl/demux_stream_if.sv
// Stream bundle between one shared producer and N demultiplexed consumers.
// master drives the input beat and consumer readies; slave is the demultiplexer.
interface demux_stream_if #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int CW = 8
);
    logic                  i_in_vld;
    logic [N-1:0]          i_in_sel;
    logic [W-1:0]          i_in_data;
    logic                  o_in_rdy;
    logic [N-1:0]          o_out_vld;
    logic [N-1:0][W-1:0]   o_out_data;
    logic [N-1:0]          i_out_rdy;
    logic                  i_err_clr;
    logic                  o_err_sel;
    logic [CW-1:0]         o_drop_cnt;

    modport master (
        output i_in_vld, i_in_sel, i_in_data, i_out_rdy, i_err_clr,
        input  o_in_rdy, o_out_vld, o_out_data, o_err_sel, o_drop_cnt
    );

    modport slave (
        input  i_in_vld, i_in_sel, i_in_data, i_out_rdy, i_err_clr,
        output o_in_rdy, o_out_vld, o_out_data, o_err_sel, o_drop_cnt
    );
endinterface

// File: rtl/demux_stream.sv
// One-hot stream demux: routes each input beat into one of N single-entry output slots.
// Latency: 1 cycle from accepted beat to o_out_vld; full 1 beat/cycle per slot.
// Backpressure: o_in_rdy drops only when the selected slot is full and not popping.
module demux_stream #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           arst_n,
    demux_stream_if.slave  bus
);

    logic [N-1:0]          vld_q;
    logic [N-1:0][W-1:0]   dat_q;
    logic                  err_q;
    logic [CW-1:0]         cnt_q;

    logic                  sel_ok;
    logic                  in_rdy;
    logic                  drop;
    logic [N-1:0]          push_vec;
    logic [N-1:0]          pop_vec;

    // Illegal selects are always accepted so a bad beat can never wedge the producer.
    assign sel_ok   = $onehot(bus.i_in_sel);
    assign in_rdy   = sel_ok ? |(bus.i_in_sel & (~vld_q | bus.i_out_rdy)) : 1'b1;
    assign drop     = bus.i_in_vld & ~sel_ok;
    assign push_vec = (bus.i_in_vld & sel_ok & in_rdy) ? bus.i_in_sel : '0;
    assign pop_vec  = vld_q & bus.i_out_rdy;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push_vec[k]) begin
                    vld_q[k] <= 1'b1;
                    dat_q[k] <= bus.i_in_data;
                end else if (pop_vec[k]) begin
                    vld_q[k] <= 1'b0;
                end
            end
        end
    end

    // Drop takes priority over the clear so a coincident error is never lost.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (drop) begin
                err_q <= 1'b1;
                if (cnt_q != {CW{1'b1}})
                    cnt_q <= cnt_q + CW'(1);
            end else if (bus.i_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.o_in_rdy   = in_rdy;
    assign bus.o_out_vld  = vld_q;
    assign bus.o_out_data = dat_q;
    assign bus.o_err_sel  = err_q;
    assign bus.o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed plus randomized bench for demux_stream against a per-slot queue model.
// Uses CW=2 so drop-counter saturation is reachable in a short run.
module tb_demux_stream;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    demux_stream_if #(.N(N), .W(W), .CW(CW)) bus ();
    demux_stream #(.N(N), .W(W), .CW(CW)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each slot is a queue of capacity one.
    logic [W-1:0] slot_q [N][$];
    logic [W-1:0] last_dat [N];
    logic         m_err;
    int           m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            slot_q[j].delete();
            last_dat[j] = '0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk_state(input string tag);
        logic [N-1:0] ev;
        for (int j = 0; j < N; j++) begin
            ev[j] = (slot_q[j].size() != 0);
            chk($sformatf("%s_dat%0d", tag, j), 64'(bus.o_out_data[j]), 64'(last_dat[j]));
        end
        chk({tag, "_vld"}, 64'(bus.o_out_vld), 64'(ev));
        chk({tag, "_err"}, 64'(bus.o_err_sel), 64'(m_err));
        chk({tag, "_cnt"}, 64'(bus.o_drop_cnt), 64'(m_cnt));
    endtask

    // Drive one cycle of inputs, check outputs, advance the model, cross one edge.
    task automatic apply(input string tag, input logic v, input logic [N-1:0] s,
                         input logic [W-1:0] d, input logic [N-1:0] r, input logic c,
                         output logic acc);
        int  k;
        bit  legal;
        bit  exp_rdy;
        bus.i_in_vld  = v;
        bus.i_in_sel  = s;
        bus.i_in_data = d;
        bus.i_out_rdy = r;
        bus.i_err_clr = c;
        #1;
        chk_state(tag);
        legal = ($countones(s) == 1);
        k = 0;
        for (int j = 0; j < N; j++) if (s[j]) k = j;
        exp_rdy = legal ? ((slot_q[k].size() == 0) || r[k]) : 1'b1;
        chk({tag, "_rdy"}, 64'(bus.o_in_rdy), 64'(exp_rdy));
        acc = v && exp_rdy;
        for (int j = 0; j < N; j++)
            if (r[j] && slot_q[j].size() != 0) void'(slot_q[j].pop_front());
        if (acc && legal) begin
            slot_q[k].push_back(d);
            last_dat[k] = d;
        end
        if (c) m_err = 1'b0;
        if (v && !legal) begin
            m_err = 1'b1;
            if (m_cnt < CMAX) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic acc;
        logic pv;
        logic [N-1:0] ps;
        logic [W-1:0] pd;
        int r;

        model_reset();
        bus.i_in_vld = 1'b0; bus.i_in_sel = '0; bus.i_in_data = '0;
        bus.i_out_rdy = '0;  bus.i_err_clr = 1'b0;

        // Reset held with random traffic: nothing may be captured.
        for (int i = 0; i < 4; i++) begin
            bus.i_in_vld  = 1'($urandom);
            bus.i_in_sel  = N'(1) << $urandom_range(0, N - 1);
            bus.i_in_data = $urandom;
            bus.i_out_rdy = N'($urandom);
            bus.i_err_clr = 1'($urandom);
            #1;
            chk_state("reset");
            chk("reset_rdy", 64'(bus.o_in_rdy), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.i_in_vld = 1'b0;
        arst_n = 1'b1;
        apply("idle", 1'b0, '0, '0, '0, 1'b0, acc);

        // Single route then backpressure on slot 2.
        apply("route", 1'b1, 4'b0100, 32'hA5A5_0001, 4'b0000, 1'b0, acc);
        apply("stall", 1'b1, 4'b0100, 32'h2, 4'b0000, 1'b0, acc);
        chk("stall_held", 64'(acc), 64'd0);
        apply("unstall", 1'b1, 4'b0100, 32'h2, 4'b0100, 1'b0, acc);
        apply("after", 1'b0, '0, '0, 4'b0000, 1'b0, acc);

        // Streaming across all slots at full rate.
        for (int i = 0; i < 16; i++)
            apply("stream", 1'b1, N'(1) << (i % N), W'(i), 4'hF, 1'b0, acc);
        apply("drain", 1'b0, '0, '0, 4'hF, 1'b0, acc);

        // Illegal selects, error clear, and drop beating a clear.
        apply("ill0", 1'b1, 4'b0000, 32'hDEAD_0000, 4'h0, 1'b0, acc);
        apply("ill1", 1'b1, 4'b0011, 32'hDEAD_0001, 4'h0, 1'b0, acc);
        apply("clr", 1'b0, '0, '0, 4'h0, 1'b1, acc);
        apply("dropclr", 1'b1, 4'b1111, 32'hDEAD_0002, 4'h0, 1'b1, acc);
        apply("postdrop", 1'b0, '0, '0, 4'h0, 1'b0, acc);

        // Random traffic; the producer keeps a beat stable until it is taken.
        pv = 1'b0; ps = '0; pd = '0; acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!pv || acc) begin
                pv = ($urandom_range(0, 3) != 0);
                r  = $urandom_range(0, 9);
                if (r == 0)      ps = '0;
                else if (r == 1) ps = N'($urandom) | 4'b0011;
                else             ps = N'(1) << $urandom_range(0, N - 1);
                pd = $urandom;
            end
            apply("rand", pv, ps, pd, N'($urandom), ($urandom_range(0, 9) == 0), acc);
        end

        // Fill every slot, then reset mid-stream: slots vanish without a clock edge.
        apply("flush", 1'b0, '0, '0, 4'hF, 1'b0, acc);
        for (int j = 0; j < N; j++)
            apply("fill", 1'b1, N'(1) << j, 32'hF00D_0000 + W'(j), 4'h0, 1'b0, acc);
        arst_n = 1'b0;
        #1;
        model_reset();
        chk_state("midrst");
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Saturation from a freshly reset counter.
        for (int i = 0; i < 5; i++)
            apply("sat", 1'b1, 4'b0000, W'(i), 4'h0, 1'b0, acc);
        apply("satend", 1'b0, '0, '0, 4'h0, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
